fetch_unit: RTL and testbench

- Instruction fetch front end. Sits directly upstream of the core's IF/DR pipeline register.
- Owns the program counter and drives the synchronous instruction memory (1-cycle read latency).
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Branches, jumps and traps resolved downstream arrive as a redirect, which flushes all wrong-path state.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries.
// Flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one-outstanding reads to a
// 1-cycle synchronous instruction memory and buffers results for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthCnt = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, inflight_pc_q;
  logic          inflight_q;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full, fifo_push, pop;
  logic [CW:0]   occupancy;
  fetch_entry_t  fifo_head, push_entry;

  assign if_valid = ~fifo_empty;
  assign pop      = if_valid & if_ready;
  assign if_instr = fifo_head.instr;
  assign if_pc    = fifo_head.pc;

  always_comb begin
    // Credit: buffered + outstanding - leaving this cycle must leave a free slot.
    occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    imem_en    = ~rst & (redirect_valid | (occupancy < DepthCnt));
    imem_addr  = redirect_valid ? align_word(redirect_pc) : pc_q;
    // The full term never blocks under the credit rule; it guards the FIFO anyway.
    fifo_push  = inflight_q & ~redirect_valid & (~fifo_full | pop);
    push_entry = '{instr: imem_rdata, pc: inflight_pc_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (imem_en) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= imem_addr;
      pc_q          <= imem_addr + 32'd4;
    end else begin
      inflight_q <= 1'b0;
      if (redirect_valid) pc_q <= align_word(redirect_pc);
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns addr ^ 32'h13.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int   n_total = 0;
  int   n_bad   = 0;
  logic overflow_seen = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h8000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_ready      (if_ready),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ 32'h13;
  end

  always @(posedge clk) begin
    if (!rst && dut.fifo_full && dut.inflight_q && !redirect_valid && !(if_valid && if_ready))
      overflow_seen <= 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset release and streaming
    cyc; #1;
    check_val("rst_en", 32'(imem_en), 32'd0);
    check_val("rst_valid", 32'(if_valid), 32'd0);
    rst = 1'b0; #1;
    check_val("c0_en", 32'(imem_en), 32'd1);
    check_val("c0_addr", imem_addr, 32'h8000_0000);
    check_val("c0_valid", 32'(if_valid), 32'd0);
    cyc; #1;
    check_val("c1_addr", imem_addr, 32'h8000_0004);
    check_val("c1_valid", 32'(if_valid), 32'd0);
    cyc; #1;
    check_val("c2_valid", 32'(if_valid), 32'd1);
    check_val("c2_pc", if_pc, 32'h8000_0000);
    check_val("c2_instr", if_instr, 32'h8000_0013);
    check_val("c2_addr", imem_addr, 32'h8000_0008);
    for (int i = 1; i <= 3; i++) begin
      cyc; #1;
      check_val("str_valid", 32'(if_valid), 32'd1);
      check_val("str_pc", if_pc, 32'h8000_0000 + 32'(4 * i));
      check_val("str_instr", if_instr, (32'h8000_0000 + 32'(4 * i)) ^ 32'h13);
    end

    // Backpressure
    rst = 1'b1; if_ready = 1'b0;
    cyc;
    rst = 1'b0; #1;
    cyc; #1;
    cyc; #1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", 32'(if_valid), 32'd1);
      check_val("bp_pc", if_pc, 32'h8000_0000);
      check_val("bp_instr", if_instr, 32'h8000_0013);
      check_val("bp_en", 32'(imem_en), 32'd0);
      cyc; #1;
    end
    if_ready = 1'b1; #1;
    check_val("rel_pc0", if_pc, 32'h8000_0000);
    check_val("rel_en", 32'(imem_en), 32'd1);
    check_val("rel_addr", imem_addr, 32'h8000_0008);
    cyc; #1;
    check_val("rel_valid1", 32'(if_valid), 32'd1);
    check_val("rel_pc1", if_pc, 32'h8000_0004);
    cyc; #1;
    check_val("rel_valid2", 32'(if_valid), 32'd1);
    check_val("rel_pc2", if_pc, 32'h8000_0008);

    // Redirect with one buffered, one in flight
    rst = 1'b1; if_ready = 1'b0;
    cyc;
    rst = 1'b0; #1;
    cyc; #1;
    cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103; #1;
    check_val("rd_en", 32'(imem_en), 32'd1);
    check_val("rd_addr", imem_addr, 32'h8000_0100);
    cyc;
    redirect_valid = 1'b0; if_ready = 1'b1; #1;
    check_val("rd_flushed", 32'(if_valid), 32'd0);
    check_val("rd_addr2", imem_addr, 32'h8000_0104);
    cyc; #1;
    check_val("rd_valid", 32'(if_valid), 32'd1);
    check_val("rd_pc", if_pc, 32'h8000_0100);
    check_val("rd_instr", if_instr, 32'h8000_0113);
    cyc; #1;
    check_val("rd_pc2", if_pc, 32'h8000_0104);

    // Redirect coincident with pop, FIFO full
    rst = 1'b1; if_ready = 1'b0;
    cyc;
    rst = 1'b0; #1;
    cyc; #1;
    cyc; #1;
    cyc; #1;
    check_val("full_en", 32'(imem_en), 32'd0);
    cyc;
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; #1;
    check_val("rp_pop_pc", if_pc, 32'h8000_0000);
    check_val("rp_addr", imem_addr, 32'h8000_0200);
    cyc;
    redirect_valid = 1'b0; #1;
    check_val("rp_empty", 32'(if_valid), 32'd0);
    cyc; #1;
    check_val("rp_valid", 32'(if_valid), 32'd1);
    check_val("rp_pc", if_pc, 32'h8000_0200);

    // Reset with a request in flight
    rst = 1'b1; if_ready = 1'b1;
    cyc;
    rst = 1'b0; #1;
    check_val("mr_addr0", imem_addr, 32'h8000_0000);
    cyc;
    rst = 1'b1; #1;
    check_val("mr_en_rst", 32'(imem_en), 32'd0);
    cyc;
    rst = 1'b0; #1;
    check_val("mr_valid0", 32'(if_valid), 32'd0);
    check_val("mr_en", 32'(imem_en), 32'd1);
    check_val("mr_addr", imem_addr, 32'h8000_0000);
    cyc; #1;
    check_val("mr_valid1", 32'(if_valid), 32'd0);
    cyc; #1;
    check_val("mr_valid2", 32'(if_valid), 32'd1);
    check_val("mr_pc", if_pc, 32'h8000_0000);

    // Redirect to the top of the address space wraps to zero
    rst = 1'b1; if_ready = 1'b1;
    cyc;
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    check_val("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cyc;
    redirect_valid = 1'b0; #1;
    check_val("wr_addr_next", imem_addr, 32'h0000_0000);
    cyc; #1;
    check_val("wr_pc", if_pc, 32'hFFFF_FFFC);
    check_val("wr_instr", if_instr, 32'hFFFF_FFEF);
    cyc; #1;
    check_val("wr_pc_wrap", if_pc, 32'h0000_0000);
    check_val("wr_instr_wrap", if_instr, 32'h0000_0013);

    check_val("no_full_push", 32'(overflow_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
